// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared opcodes, forward-select encodings and tracker slot record
package hazard_pkg;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_SD    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   // rs1/rs2 hold x0 when the instruction does not read that operand,
   // so an unused source field can never produce a hazard or forward.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } slot_t;

   // True when slot s produces a value that source register rs consumes.
   function automatic logic slot_hit(input slot_t s, input logic [4:0] rs);
      return s.valid && s.regwrite && (s.rd != 5'd0) && (s.rd == rs);
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - forward select for one EX source register against MEM/WB slots
module hazard_fwd_sel
   import hazard_pkg::*;
(
   input  slot_t      mem_slot,
   input  slot_t      wb_slot,
   input  logic [4:0] rs,
   output logic [1:0] sel
);

   // Youngest producer wins: MEM result is newer than WB result.
   always_comb begin
      sel = FWD_RF;
      if (slot_hit(mem_slot, rs)) begin
         sel = FWD_EXMEM;
      end else if (slot_hit(wb_slot, rs)) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller; FORWARDING_EN selects forwarding vs full interlock
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [31:0]      id_inst,
   input  logic             ex_branch_taken,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt
);

   slot_t id_rec;
   slot_t ex_slot;
   slot_t mem_slot;
   slot_t wb_slot;
   logic  raw_hazard;

   // Decode the ID instruction into a tracker record; invalid ID yields an all-zero record.
   always_comb begin
      id_rec = '0;
      if (id_valid) begin
         id_rec.valid = 1'b1;
         id_rec.rd    = id_inst[11:7];
         unique case (id_inst[6:0])
            OP_RTYPE: begin
               id_rec.regwrite = 1'b1;
               id_rec.rs1      = id_inst[19:15];
               id_rec.rs2      = id_inst[24:20];
            end
            OP_LD: begin
               id_rec.regwrite = 1'b1;
               id_rec.memread  = 1'b1;
               id_rec.rs1      = id_inst[19:15];
            end
            OP_SD, OP_BEQ: begin
               id_rec.rs1 = id_inst[19:15];
               id_rec.rs2 = id_inst[24:20];
            end
            default: ;
         endcase
      end
   end

   // Decide whether the ID instruction must wait; WB is never checked because the regfile writes on negedge.
   always_comb begin
`ifdef FORWARDING_EN
      raw_hazard = ex_slot.memread &&
                   (slot_hit(ex_slot, id_rec.rs1) || slot_hit(ex_slot, id_rec.rs2));
`else
      raw_hazard = slot_hit(ex_slot, id_rec.rs1)  || slot_hit(ex_slot, id_rec.rs2) ||
                   slot_hit(mem_slot, id_rec.rs1) || slot_hit(mem_slot, id_rec.rs2);
`endif
   end

   // Pipeline control: a taken branch flushes and overrides any stall; reset silences everything.
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (!rst) begin
         if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (raw_hazard) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
         end
      end
   end

`ifdef FORWARDING_EN
   logic [1:0] sel_a;
   logic [1:0] sel_b;

   hazard_fwd_sel u_fwd_a (
      .mem_slot (mem_slot),
      .wb_slot  (wb_slot),
      .rs       (ex_slot.rs1),
      .sel      (sel_a)
   );

   hazard_fwd_sel u_fwd_b (
      .mem_slot (mem_slot),
      .wb_slot  (wb_slot),
      .rs       (ex_slot.rs2),
      .sel      (sel_b)
   );

   assign fwd_a = rst ? FWD_RF : sel_a;
   assign fwd_b = rst ? FWD_RF : sel_b;
`else
   assign fwd_a = FWD_RF;
   assign fwd_b = FWD_RF;
`endif

   // Sinks for instruction and slot fields that some build variants never read.
   logic unused_bits;
   assign unused_bits = ^{id_inst[31:25], id_inst[14:12], ex_slot, mem_slot, wb_slot};

   // Advance the in-flight tracker; a bubble enters EX when ID is held or flushed.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_slot  <= '0;
         mem_slot <= '0;
         wb_slot  <= '0;
      end else begin
         wb_slot  <= mem_slot;
         mem_slot <= ex_slot;
         ex_slot  <= idex_bubble ? '0 : id_rec;
      end
   end

   // Saturating count of cycles spent with the PC held.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
